gcbp_subimage_writer: RTL and testbench

- Consumes GCBP sub-image lines from the line generator: 128-bit line, valid strobe, horizontal sub-image index.
- Tracks the vertical position in the frame and keeps only lines inside the two vertical sub-image rows.
- Writes each kept line into a ping-pong sub-image BRAM: 2 banks × 8 sub-images × 128 lines × 128 bits.
- Signals the downstream block-matching stage when a full frame bank is complete.

---
 rtl/gcbp_subimage_writer.sv | 184 ++++++++++++++++++
 tb/tb_gcbp_subimage_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcbp_subimage_writer.sv
// Stores the two vertical GCBP sub-image rows of each frame into a ping-pong BRAM bank.
// Optional saturating drop/error counters are enabled with GCBP_WRITER_STATS_EN.
module gcbp_subimage_writer #(
    parameter int BRAM_DATA_WIDTH             = 128,
    parameter int C_FRAME_LINES               = 480,
    parameter int C_VERT_EDGE_TO_SUBIMAGE     = 75,
    parameter int C_VERT_SUBIMAGE_TO_SUBIMAGE = 74,
    parameter int C_SUBIMAGE_HEIGHT           = 128,
    parameter int C_ADDR_BITS                 = 11
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_new_frame,
    input  logic                       i_new_line,
    input  logic [BRAM_DATA_WIDTH-1:0] i_gcbp_line,
    input  logic                       i_gcbp_line_valid,
    input  logic [1:0]                 i_hori_subimage_cnt,
    input  logic                       i_consumer_ready,
    output logic                       o_bram_we,
    output logic [C_ADDR_BITS-1:0]     o_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] o_bram_wdata,
    output logic                       o_frame_done,
    output logic                       o_frame_bank,
    output logic                       o_frame_dropped,
    output logic                       o_frame_error
`ifdef GCBP_WRITER_STATS_EN
    ,
    output logic [7:0]                 o_dropped_cnt,
    output logic [7:0]                 o_error_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_ROW0, S_GAP, S_ROW1, S_CHECK, S_SKIP
    } state_t;

    localparam logic [9:0]  FRAME_LINES = 10'(C_FRAME_LINES);
    localparam logic [9:0]  ROW0_FIRST  = 10'(C_VERT_EDGE_TO_SUBIMAGE + 1);
    localparam logic [9:0]  ROW0_END    = 10'(C_VERT_EDGE_TO_SUBIMAGE + 1 + C_SUBIMAGE_HEIGHT);
    localparam logic [9:0]  ROW1_FIRST  = 10'(C_VERT_EDGE_TO_SUBIMAGE + 1 + C_SUBIMAGE_HEIGHT
                                              + C_VERT_SUBIMAGE_TO_SUBIMAGE);
    localparam logic [9:0]  ROW1_END    = 10'(C_VERT_EDGE_TO_SUBIMAGE + 1 + 2 * C_SUBIMAGE_HEIGHT
                                              + C_VERT_SUBIMAGE_TO_SUBIMAGE);
    localparam logic [10:0] FULL_WRITES = 11'(8 * C_SUBIMAGE_HEIGHT);

    state_t                     state_q, state_d;
    logic [9:0]                 line_cnt_q, line_cnt_d;
    logic [10:0]                write_cnt_q, write_cnt_d;
    logic                       bank_q, bank_d;
    logic                       frame_bank_q, frame_bank_d;
    logic                       done_q, done_d;
    logic                       dropped_q, dropped_d;
    logic                       error_q, error_d;
    logic                       we_q, we_d;
    logic [C_ADDR_BITS-1:0]     addr_q, addr_d;
    logic [BRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [6:0]                 row_line;
    logic                       in_row;

    assign in_row   = (state_q == S_ROW0) || (state_q == S_ROW1);
    assign row_line = (state_q == S_ROW1) ? 7'(line_cnt_q - ROW1_FIRST)
                                          : 7'(line_cnt_q - ROW0_FIRST);

    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        write_cnt_d  = write_cnt_q;
        bank_d       = bank_q;
        frame_bank_d = frame_bank_q;
        done_d       = 1'b0;
        dropped_d    = 1'b0;
        error_d      = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        // The frame-start pulse is also the first line's pulse, so that line becomes line 1.
        if (i_new_frame) begin
            line_cnt_d = i_new_line ? 10'd1 : 10'd0;
        end else if (i_new_line && (line_cnt_q != FRAME_LINES)) begin
            line_cnt_d = line_cnt_q + 10'd1;
        end

        if (i_new_frame) begin
            write_cnt_d = '0;
            if ((state_q != S_IDLE) && (state_q != S_SKIP)) begin
                error_d = 1'b1;
            end
            if (i_consumer_ready) begin
                state_d = S_TOP;
            end else begin
                state_d   = S_SKIP;
                dropped_d = 1'b1;
            end
        end else begin
            if (in_row && i_gcbp_line_valid) begin
                we_d        = 1'b1;
                addr_d      = {bank_q, (state_q == S_ROW1), i_hori_subimage_cnt, row_line};
                wdata_d     = i_gcbp_line;
                write_cnt_d = write_cnt_q + 11'd1;
            end
            case (state_q)
                S_TOP:   if (line_cnt_d == ROW0_FIRST) state_d = S_ROW0;
                S_ROW0:  if (line_cnt_d == ROW0_END)   state_d = S_GAP;
                S_GAP:   if (line_cnt_d == ROW1_FIRST) state_d = S_ROW1;
                S_ROW1:  if (line_cnt_d == ROW1_END)   state_d = S_CHECK;
                S_CHECK: begin
                    if (write_cnt_q == FULL_WRITES) begin
                        done_d       = 1'b1;
                        frame_bank_d = bank_q;
                        bank_d       = ~bank_q;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                S_IDLE, S_SKIP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q      <= S_IDLE;
            line_cnt_q   <= '0;
            write_cnt_q  <= '0;
            bank_q       <= 1'b0;
            frame_bank_q <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= 1'b0;
            error_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            write_cnt_q  <= write_cnt_d;
            bank_q       <= bank_d;
            frame_bank_q <= frame_bank_d;
            done_q       <= done_d;
            dropped_q    <= dropped_d;
            error_q      <= error_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign o_bram_we       = we_q;
    assign o_bram_addr     = addr_q;
    assign o_bram_wdata    = wdata_q;
    assign o_frame_done    = done_q;
    assign o_frame_bank    = frame_bank_q;
    assign o_frame_dropped = dropped_q;
    assign o_frame_error   = error_q;

`ifdef GCBP_WRITER_STATS_EN
    logic [7:0] dropped_cnt_q, dropped_cnt_d;
    logic [7:0] error_cnt_q, error_cnt_d;

    always_comb begin
        dropped_cnt_d = dropped_cnt_q;
        error_cnt_d   = error_cnt_q;
        if (dropped_d && (dropped_cnt_q != 8'hFF)) dropped_cnt_d = dropped_cnt_q + 8'd1;
        if (error_d && (error_cnt_q != 8'hFF))     error_cnt_d   = error_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            dropped_cnt_q <= '0;
            error_cnt_q   <= '0;
        end else begin
            dropped_cnt_q <= dropped_cnt_d;
            error_cnt_q   <= error_cnt_d;
        end
    end

    assign o_dropped_cnt = dropped_cnt_q;
    assign o_error_cnt   = error_cnt_q;
`endif

endmodule

// File: tb/tb_gcbp_subimage_writer.sv
// Frame-level bench for gcbp_subimage_writer: table of frame scenarios, write scoreboard,
// and hand-written reset / frame-start corner cases.
module tb_gcbp_subimage_writer;

    logic         i_clk = 1'b0;
    logic         i_resetn;
    logic         i_new_frame;
    logic         i_new_line;
    logic [127:0] i_gcbp_line;
    logic         i_gcbp_line_valid;
    logic [1:0]   i_hori_subimage_cnt;
    logic         i_consumer_ready;
    logic         o_bram_we;
    logic [10:0]  o_bram_addr;
    logic [127:0] o_bram_wdata;
    logic         o_frame_done;
    logic         o_frame_bank;
    logic         o_frame_dropped;
    logic         o_frame_error;
`ifdef GCBP_WRITER_STATS_EN
    logic [7:0]   o_dropped_cnt;
    logic [7:0]   o_error_cnt;
`endif

    always #5 i_clk = ~i_clk;

    gcbp_subimage_writer dut (
        .i_clk               (i_clk),
        .i_resetn            (i_resetn),
        .i_new_frame         (i_new_frame),
        .i_new_line          (i_new_line),
        .i_gcbp_line         (i_gcbp_line),
        .i_gcbp_line_valid   (i_gcbp_line_valid),
        .i_hori_subimage_cnt (i_hori_subimage_cnt),
        .i_consumer_ready    (i_consumer_ready),
        .o_bram_we           (o_bram_we),
        .o_bram_addr         (o_bram_addr),
        .o_bram_wdata        (o_bram_wdata),
        .o_frame_done        (o_frame_done),
        .o_frame_bank        (o_frame_bank),
        .o_frame_dropped     (o_frame_dropped),
        .o_frame_error       (o_frame_error)
`ifdef GCBP_WRITER_STATS_EN
        ,
        .o_dropped_cnt       (o_dropped_cnt),
        .o_error_cnt         (o_error_cnt)
`endif
    );

    typedef struct {
        logic [10:0]  addr;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic ready;
        int   nlines;
        logic dup;
        logic nf_valid;
        int   writes;
        int   done;
        int   dropped;
        int   err;
        logic bank_out;
    } vec_t;

    wr_t  sb[$];
    int   checks = 0;
    int   passes = 0;
    int   done_seen = 0;
    int   drop_seen = 0;
    int   err_seen = 0;
    int   wr_seen = 0;
    logic last_done_bank = 1'b0;
    logic exp_bank = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, then sample outputs on the following falling edge.
    task automatic applyStimulus(input logic nf, input logic nl, input logic v,
                                 input logic [1:0] h, input logic [127:0] d);
        wr_t e;
        i_new_frame         = nf;
        i_new_line          = nl;
        i_gcbp_line_valid   = v;
        i_hori_subimage_cnt = h;
        i_gcbp_line         = d;
        @(negedge i_clk);
        if (o_bram_we) begin
            wr_seen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_we", 128'(o_bram_we), 128'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("wr_addr", 128'(o_bram_addr), 128'(e.addr));
                checkOutput("wr_data", o_bram_wdata, e.data);
            end
        end
        if (o_frame_done) begin
            done_seen++;
            last_done_bank = o_frame_bank;
        end
        if (o_frame_dropped) drop_seen++;
        if (o_frame_error)   err_seen++;
    endtask

    task automatic run_frame(input logic ready, input int nlines, input logic dup, input logic nf_valid);
        logic [127:0] d;
        logic [1:0]   hs;
        logic         win;
        logic         vrow;
        int           base;
        int           nv;
        wr_t          e;
        i_consumer_ready = ready;
        for (int l = 1; l <= nlines; l++) begin
            if (l == 1 && nf_valid) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, {$urandom, $urandom, $urandom, $urandom});
                checkOutput("nf_valid_dropped", 128'(o_bram_we), 128'(0));
            end else begin
                applyStimulus(l == 1, 1'b1, 1'b0, 2'd0, '0);
            end
            win  = (l >= 76 && l <= 203) || (l >= 278 && l <= 405);
            vrow = (l >= 278);
            base = vrow ? 278 : 76;
            nv   = (dup && l == 100) ? 5 : 4;
            for (int h = 0; h < nv; h++) begin
                hs = 2'(h % 4);
                d  = {$urandom, $urandom, $urandom, $urandom};
                if (ready && win) begin
                    e.addr = {exp_bank, vrow, hs, 7'(l - base)};
                    e.data = d;
                    sb.push_back(e);
                end
                applyStimulus(1'b0, 1'b0, 1'b1, hs, d);
                if (ready && l == 76 && h == 0) begin
                    checkOutput("line76_we", 128'(o_bram_we), 128'(1));
                    checkOutput("line76_addr", 128'(o_bram_addr), 128'({exp_bank, 10'd0}));
                end
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    initial begin
        vec_t vecs[6];
        int   d0, p0, e0, w0;

        vecs[0] = '{1'b1, 480, 1'b0, 1'b0, 1024, 1, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 480, 1'b0, 1'b0, 1024, 1, 0, 0, 1'b1};
        vecs[2] = '{1'b0, 480, 1'b0, 1'b0, 0,    0, 1, 0, 1'b1};
        vecs[3] = '{1'b1, 149, 1'b0, 1'b0, 296,  0, 0, 0, 1'b1};
        vecs[4] = '{1'b1, 480, 1'b0, 1'b1, 1024, 1, 0, 1, 1'b0};
        vecs[5] = '{1'b1, 480, 1'b1, 1'b0, 1025, 0, 0, 1, 1'b0};

        i_resetn         = 1'b0;
        i_consumer_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
        checkOutput("rst_we",      128'(o_bram_we), 128'(0));
        checkOutput("rst_addr",    128'(o_bram_addr), 128'(0));
        checkOutput("rst_wdata",   o_bram_wdata, 128'(0));
        checkOutput("rst_done",    128'(o_frame_done), 128'(0));
        checkOutput("rst_bank",    128'(o_frame_bank), 128'(0));
        checkOutput("rst_dropped", 128'(o_frame_dropped), 128'(0));
        checkOutput("rst_error",   128'(o_frame_error), 128'(0));
        i_resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);

        for (int i = 0; i < 6; i++) begin
            d0 = done_seen; p0 = drop_seen; e0 = err_seen; w0 = wr_seen;
            run_frame(vecs[i].ready, vecs[i].nlines, vecs[i].dup, vecs[i].nf_valid);
            checkOutput($sformatf("row%0d_writes", i),  128'(wr_seen - w0),   128'(vecs[i].writes));
            checkOutput($sformatf("row%0d_done", i),    128'(done_seen - d0), 128'(vecs[i].done));
            checkOutput($sformatf("row%0d_dropped", i), 128'(drop_seen - p0), 128'(vecs[i].dropped));
            checkOutput($sformatf("row%0d_error", i),   128'(err_seen - e0),  128'(vecs[i].err));
            checkOutput($sformatf("row%0d_bank", i),    128'(o_frame_bank),   128'(vecs[i].bank_out));
            checkOutput($sformatf("row%0d_sb_left", i), 128'(sb.size()),      128'(0));
            if (vecs[i].done != 0) begin
                checkOutput($sformatf("row%0d_done_bank", i), 128'(last_done_bank), 128'(vecs[i].bank_out));
                exp_bank = ~exp_bank;
            end
        end

        // Reset in the middle of row 0 with a valid present: everything clears next cycle.
        run_frame(1'b1, 100, 1'b0, 1'b0);
        i_resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, {4{32'hDEADBEEF}});
        checkOutput("mid_rst_we",    128'(o_bram_we), 128'(0));
        checkOutput("mid_rst_addr",  128'(o_bram_addr), 128'(0));
        checkOutput("mid_rst_wdata", o_bram_wdata, 128'(0));
        checkOutput("mid_rst_bank",  128'(o_frame_bank), 128'(0));
        checkOutput("mid_rst_error", 128'(o_frame_error), 128'(0));
        checkOutput("mid_rst_sb",    128'(sb.size()), 128'(0));
        i_resetn = 1'b1;
        exp_bank = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);

        d0 = done_seen; e0 = err_seen; w0 = wr_seen;
        run_frame(1'b1, 480, 1'b0, 1'b0);
        checkOutput("post_rst_writes",    128'(wr_seen - w0),   128'(1024));
        checkOutput("post_rst_done",      128'(done_seen - d0), 128'(1));
        checkOutput("post_rst_done_bank", 128'(last_done_bank), 128'(0));
        checkOutput("post_rst_error",     128'(err_seen - e0),  128'(0));
        checkOutput("post_rst_sb_left",   128'(sb.size()),      128'(0));
`ifdef GCBP_WRITER_STATS_EN
        checkOutput("stats_dropped", 128'(o_dropped_cnt), 128'(0));
        checkOutput("stats_error",   128'(o_error_cnt),   128'(0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
